// File: rtl/digit_scan_decoder_pkg.sv
// rtl/digit_scan_decoder_pkg.sv - scan FSM encoding and sizing helper for the digit scanner
package digit_scan_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } scan_state_t;

   // Bits needed to hold 0..value-1, never less than one.
   function automatic int clog2_min1(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/digit_scan_decoder_tick_gen.sv
// rtl/digit_scan_decoder_tick_gen.sv - slot prescaler with slot-end and dead-time strobes
module digit_scan_decoder_tick_gen
   import digit_scan_decoder_pkg::*;
#(
   parameter int  CLK_DIV  = 100000,
   parameter int  DEAD_CYC = 2,
   localparam int PRE_W    = clog2_min1(CLK_DIV)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [PRE_W-1:0] pre,
   output logic             slot_end,
   output logic             dead_done
);

   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_DIV - 1);
   localparam logic [PRE_W-1:0] DEAD_LAST = PRE_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
      end else if (!en || pre == PRE_LAST) begin
         pre <= '0;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   assign slot_end  = en && (pre == PRE_LAST);
   assign dead_done = en && (DEAD_CYC > 0) && (pre == DEAD_LAST);

endmodule

// File: rtl/digit_scan_decoder.sv
// rtl/digit_scan_decoder.sv - time-multiplexed active-low digit select with dead time and blanking
module digit_scan_decoder
   import digit_scan_decoder_pkg::*;
#(
   parameter int  NUM_SEL  = 4,
   parameter int  CLK_DIV  = 100000,
   parameter int  DEAD_CYC = 2,
   localparam int ADDR_W   = clog2_min1(NUM_SEL)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              manual,
   input  logic [ADDR_W-1:0] addr,
   input  logic [NUM_SEL-1:0] blank_mask,
   output logic [NUM_SEL-1:0] sel_n,
   output logic [ADDR_W-1:0] cur_addr,
   output logic              tick,
   output logic              frame
);

   localparam int                PRE_W     = clog2_min1(CLK_DIV);
   localparam int                SPAN      = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_SEL - 1);

   logic [PRE_W-1:0]   pre;
   logic               slot_end;
   logic               dead_done;
   scan_state_t        state;
   scan_state_t        state_nxt;
   logic [SPAN-1:0]    mask_pad;
   logic               addr_ok;
   logic [NUM_SEL-1:0] sel_nxt;

   digit_scan_decoder_tick_gen #(
      .CLK_DIV  (CLK_DIV),
      .DEAD_CYC (DEAD_CYC)
   ) u_tick_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .pre       (pre),
      .slot_end  (slot_end),
      .dead_done (dead_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The IDLE cycle itself sits at pre = 0, so it already serves as the first dead clock.
   always_comb begin
      state_nxt = state;
      if (!en) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  state_nxt = (DEAD_CYC <= 1) ? ST_DRIVE : ST_BLANK;
            ST_BLANK: if (dead_done) state_nxt = ST_DRIVE;
            ST_DRIVE: if (slot_end) state_nxt = (DEAD_CYC == 0) ? ST_DRIVE : ST_BLANK;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   assign mask_pad = SPAN'(blank_mask);
   assign addr_ok  = {1'b0, cur_addr} < (ADDR_W + 1)'(NUM_SEL);

   always_comb begin
      sel_nxt = '1;
      if (state == ST_DRIVE && addr_ok && !mask_pad[cur_addr]) begin
         sel_nxt = ~(NUM_SEL'(1) << cur_addr);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_n    <= '1;
         cur_addr <= '0;
         tick     <= 1'b0;
         frame    <= 1'b0;
      end else begin
         sel_n <= sel_nxt;
         tick  <= slot_end;
         frame <= slot_end && !manual && (cur_addr == ADDR_LAST);
         if (slot_end) begin
            if (manual) begin
               cur_addr <= addr;
            end else if (cur_addr == ADDR_LAST) begin
               cur_addr <= '0;
            end else begin
               cur_addr <= cur_addr + 1'b1;
            end
         end
      end
   end

endmodule
